// File: rtl/freqsel_ce_gen_pkg.sv
// Shared types, defaults and helpers for the selectable-rate clock-enable generator.
package freqsel_pkg;

  typedef enum logic {RUN, PEND} state_t;

  localparam int DEF_N_FREQ  = 6;
  localparam int DEF_DIV_W   = 16;
  localparam int DEF_RST_SEL = 0;

  // Entry 0 sits in the low bits: {e5, e4, e3, e2, e1, e0}
  localparam logic [DEF_N_FREQ*DEF_DIV_W-1:0] DEF_DIV_TABLE =
    {16'd2, 16'd0, 16'd5, 16'd3, 16'd6, 16'd4};

  function automatic logic [31:0] div_eff(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/freqsel_ce_gen_if.sv
// Rate-select request/status bundle between the control register block and the generator.
interface freqsel_ce_gen_if #(
  parameter int SEL_W = 3
);

  logic [SEL_W-1:0] FREQ_SEL;
  logic             SEL_VALID;
  logic [SEL_W-1:0] FREQ_ACTIVE;
  logic             SWITCH_BUSY;
  logic             SWITCH_DONE;
  logic             SEL_ERR;

  modport master (
    output FREQ_SEL, SEL_VALID,
    input  FREQ_ACTIVE, SWITCH_BUSY, SWITCH_DONE, SEL_ERR
  );

  modport slave (
    input  FREQ_SEL, SEL_VALID,
    output FREQ_ACTIVE, SWITCH_BUSY, SWITCH_DONE, SEL_ERR
  );

endinterface

// File: rtl/freqsel_ce_gen_divcnt.sv
// Period counter for the active divide value: flags the wrap cycle and builds the ~50% phase.
module freqsel_divcnt
  import freqsel_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             wrap,
  output logic             phase
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W:0]   half;

  // div_act is never below 1, so D-1 cannot underflow; half is ceil(D/2) with one spare bit
  assign half = ({1'b0, div_act} + (DIV_W+1)'(1)) >> 1;
  assign wrap = en && (cnt == (div_act - DIV_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      phase   <= 1'b0;
      div_act <= DIV_W'(div_eff(32'(load_div)));
    end else begin
      if (en) begin
        phase <= ({1'b0, cnt} < half);
        cnt   <= wrap ? '0 : cnt + DIV_W'(1);
      end
      if (load) begin
        div_act <= DIV_W'(div_eff(32'(load_div)));
        cnt     <= '0;
      end
    end
  end

endmodule

// File: rtl/freqsel_ce_gen.sv
// Selectable-rate clock-enable generator; rate changes are deferred to a period boundary.
module freqsel_ce_gen
  import freqsel_pkg::*;
#(
  parameter int N_FREQ  = DEF_N_FREQ,
  parameter int DIV_W   = DEF_DIV_W,
  parameter int SEL_W   = $clog2(N_FREQ),
  parameter int RST_SEL = DEF_RST_SEL
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  input  logic [N_FREQ*DIV_W-1:0] DIV_TABLE,
  freqsel_ce_gen_if.slave         sel_bus,
  output logic                    CE_OUT,
  output logic                    PHASE_OUT
);

  localparam logic [SEL_W-1:0] RST_IDX    = SEL_W'(RST_SEL);
  localparam logic [SEL_W:0]   N_FREQ_LIM = (SEL_W+1)'(N_FREQ);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel_pend, sel_pend_nxt;
  logic [SEL_W-1:0] freq_active;
  logic             switch_done, sel_err;
  logic             wrap, apply, req_legal, req_illegal;
  logic [DIV_W-1:0] tbl [N_FREQ];
  logic [DIV_W-1:0] load_div;

  always_comb begin
    for (int i = 0; i < N_FREQ; i++) begin
      tbl[i] = DIV_TABLE[i*DIV_W +: DIV_W];
    end
  end

  assign req_legal   = sel_bus.SEL_VALID && ({1'b0, sel_bus.FREQ_SEL} < N_FREQ_LIM);
  assign req_illegal = sel_bus.SEL_VALID && !({1'b0, sel_bus.FREQ_SEL} < N_FREQ_LIM);
  assign apply       = wrap && (state == PEND);
  assign load_div    = RST ? tbl[RST_IDX] : tbl[sel_pend];

  freqsel_divcnt #(
    .DIV_W (DIV_W)
  ) u_divcnt (
    .clk      (CLK),
    .rst      (RST),
    .en       (EN),
    .load     (apply),
    .load_div (load_div),
    .wrap     (wrap),
    .phase    (PHASE_OUT)
  );

  // A request arriving in the wrap cycle overrides the clear, so it stays pending for the next wrap
  always_comb begin
    state_nxt    = state;
    sel_pend_nxt = sel_pend;
    if (apply) begin
      state_nxt = RUN;
    end
    if (req_legal) begin
      state_nxt    = PEND;
      sel_pend_nxt = sel_bus.FREQ_SEL;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= RUN;
      sel_pend    <= RST_IDX;
      freq_active <= RST_IDX;
      CE_OUT      <= 1'b0;
      switch_done <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      sel_pend    <= sel_pend_nxt;
      CE_OUT      <= wrap;
      switch_done <= apply;
      sel_err     <= req_illegal;
      if (apply) begin
        freq_active <= sel_pend;
      end
    end
  end

  assign sel_bus.FREQ_ACTIVE = freq_active;
  assign sel_bus.SWITCH_BUSY = (state == PEND);
  assign sel_bus.SWITCH_DONE = switch_done;
  assign sel_bus.SEL_ERR     = sel_err;

endmodule

// File: tb/tb_freqsel_ce_gen.sv
// Directed bench for freqsel_ce_gen: rate switching, error strobe, D=1, EN freeze and reset.
module tb_freqsel_ce_gen;
  import freqsel_pkg::*;

  localparam int N_FREQ = 6;
  localparam int DIV_W  = 16;
  localparam int SEL_W  = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en;
  logic [N_FREQ*DIV_W-1:0] div_table;
  logic                    ce_out;
  logic                    phase_out;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  freqsel_ce_gen_if #(.SEL_W(SEL_W)) sel_bus ();

  freqsel_ce_gen #(
    .N_FREQ  (N_FREQ),
    .DIV_W   (DIV_W),
    .SEL_W   (SEL_W),
    .RST_SEL (0)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .EN        (en),
    .DIV_TABLE (div_table),
    .sel_bus   (sel_bus),
    .CE_OUT    (ce_out),
    .PHASE_OUT (phase_out)
  );

  always #5 clk = ~clk;

  // Drive this cycle's inputs, then move to 1ns after the next rising edge
  task automatic apply_stimulus(input logic sv, input logic [SEL_W-1:0] fs,
                                input logic en_v, input logic rst_v);
    sel_bus.SEL_VALID = sv;
    sel_bus.FREQ_SEL  = fs;
    en                = en_v;
    rst               = rst_v;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL c%0d %s observed=%0d expected=%0d", cyc, tag, obs, exp);
    end
  endtask

  task automatic check_output(input logic ce, input logic ph, input logic busy,
                              input logic done, input logic err, input int act);
    chk("ce",     32'(ce_out),              32'(ce));
    chk("phase",  32'(phase_out),           32'(ph));
    chk("busy",   32'(sel_bus.SWITCH_BUSY), 32'(busy));
    chk("done",   32'(sel_bus.SWITCH_DONE), 32'(done));
    chk("err",    32'(sel_bus.SEL_ERR),     32'(err));
    chk("active", 32'(sel_bus.FREQ_ACTIVE), 32'(act));
  endtask

  initial begin
    div_table = DEF_DIV_TABLE;
    apply_stimulus(1'b0, 3'd0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 3'd0, 1'b1, 1'b1);
    cyc = 0;
    check_output(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // D=4 from reset, request index 2 (D=3) during cycle 6
    for (int c = 0; c < 14; c++) begin
      apply_stimulus(c == 6, 3'd2, 1'b1, 1'b0);
      check_output(cyc inside {4, 8, 11, 14},
                   cyc inside {1, 2, 5, 6, 9, 10, 12, 13},
                   cyc == 7, cyc == 8, 1'b0, (cyc >= 8) ? 2 : 0);
    end

    // Two requests before the wrap: only index 3 (D=5) lands
    apply_stimulus(1'b1, 3'd1, 1'b1, 1'b0);
    check_output(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    apply_stimulus(1'b1, 3'd3, 1'b1, 1'b0);
    check_output(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    apply_stimulus(1'b0, 3'd0, 1'b1, 1'b0);
    check_output(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    for (int c = 18; c <= 22; c++) begin
      apply_stimulus(1'b0, 3'd0, 1'b1, 1'b0);
      check_output(c == 22, c <= 20, 1'b0, 1'b0, 1'b0, 3);
    end

    // Out-of-range indices 7 and 6
    apply_stimulus(1'b1, 3'd7, 1'b1, 1'b0);
    check_output(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    apply_stimulus(1'b0, 3'd0, 1'b1, 1'b0);
    check_output(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    apply_stimulus(1'b1, 3'd6, 1'b1, 1'b0);
    check_output(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3);

    // Entry 4 holds 0 -> CE every cycle after apply
    apply_stimulus(1'b1, 3'd4, 1'b1, 1'b0);
    check_output(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3);
    apply_stimulus(1'b0, 3'd0, 1'b1, 1'b0);
    check_output(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4);
    for (int c = 28; c <= 30; c++) begin
      apply_stimulus(1'b0, 3'd0, 1'b1, 1'b0);
      check_output(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4);
    end

    // Request lands in a wrap cycle, so it waits one more wrap
    apply_stimulus(1'b1, 3'd0, 1'b1, 1'b0);
    check_output(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4);
    apply_stimulus(1'b0, 3'd0, 1'b1, 1'b0);
    check_output(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    apply_stimulus(1'b0, 3'd0, 1'b1, 1'b0);
    check_output(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    apply_stimulus(1'b0, 3'd0, 1'b1, 1'b0);
    check_output(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    apply_stimulus(1'b0, 3'd0, 1'b1, 1'b0);
    check_output(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // EN low for 5 cycles at cnt=3; a request made while frozen is still captured
    apply_stimulus(1'b0, 3'd0, 1'b0, 1'b0);
    check_output(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    apply_stimulus(1'b0, 3'd0, 1'b0, 1'b0);
    check_output(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    apply_stimulus(1'b1, 3'd5, 1'b0, 1'b0);
    check_output(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    apply_stimulus(1'b0, 3'd0, 1'b0, 1'b0);
    check_output(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    apply_stimulus(1'b0, 3'd0, 1'b0, 1'b0);
    check_output(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    apply_stimulus(1'b0, 3'd0, 1'b1, 1'b0);
    check_output(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5);
    apply_stimulus(1'b0, 3'd0, 1'b1, 1'b0);
    check_output(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    apply_stimulus(1'b0, 3'd0, 1'b1, 1'b0);
    check_output(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5);

    // Reset while a request is pending discards it; later table edits are ignored
    apply_stimulus(1'b1, 3'd1, 1'b1, 1'b0);
    check_output(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5);
    apply_stimulus(1'b0, 3'd0, 1'b1, 1'b1);
    check_output(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    div_table[DIV_W-1:0] = 16'd2;
    for (int c = 46; c <= 49; c++) begin
      apply_stimulus(1'b0, 3'd0, 1'b1, 1'b0);
      check_output(c == 49, c <= 47, 1'b0, 1'b0, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
